// File: rtl/assert_window_ctrl_pkg.sv
// Shared types and default widths for the assert window controller.
package assert_ctrl_pkg;

  localparam int unsigned CNT_W_DEF = 8;
  localparam int unsigned ERR_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_OFF     = 2'd0,
    ST_ARM_ON  = 2'd1,
    ST_ON      = 2'd2,
    ST_ARM_OFF = 2'd3
  } state_t;

endpackage

// File: rtl/assert_window_ctrl_if.sv
// Request/checker/status bundle between the config master and the window controller.
interface assert_window_ctrl_if #(
  parameter int unsigned CNT_W = assert_ctrl_pkg::CNT_W_DEF,
  parameter int unsigned ERR_W = assert_ctrl_pkg::ERR_W_DEF
) ();

  logic                    on_req;
  logic                    off_req;
  logic [CNT_W-1:0]        delay;
  logic                    chk_valid;
  logic                    chk_pass;
  logic                    clr_cnt;
  logic                    chk_en;
  assert_ctrl_pkg::state_t state;
  logic                    busy;
  logic [ERR_W-1:0]        pass_cnt;
  logic [ERR_W-1:0]        fail_cnt;
  logic                    fail_irq;

  modport master (
    output on_req, off_req, delay, chk_valid, chk_pass, clr_cnt,
    input  chk_en, state, busy, pass_cnt, fail_cnt, fail_irq
  );

  modport slave (
    input  on_req, off_req, delay, chk_valid, chk_pass, clr_cnt,
    output chk_en, state, busy, pass_cnt, fail_cnt, fail_irq
  );

endinterface

// File: rtl/assert_window_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear that wins over increment.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc && (q_q != '1)) begin
      q_d = q_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/assert_window_ctrl.sv
// Delayed enable/disable sequencer for a checker, plus pass/fail accounting
// that only counts results while the window is open.
module assert_window_ctrl
  import assert_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned ERR_W = ERR_W_DEF
) (
  input logic                clk,
  input logic                rst,
  assert_window_ctrl_if.slave bus
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             chk_en_q, chk_en_d;
  logic             busy_q, busy_d;
  logic             fail_irq_q;

  logic             dly_zero_c;
  logic [CNT_W-1:0] dly_load_c;
  logic             arming_c;
  logic             cnt_pass_c;
  logic             cnt_fail_c;

  // A zero delay jumps straight to the target; otherwise the ARM state waits D cycles.
  assign dly_zero_c = (bus.delay == '0);
  assign dly_load_c = dly_zero_c ? '0 : (bus.delay - CNT_W'(1));
  assign arming_c   = (state_q == ST_ARM_ON) || (state_q == ST_ARM_OFF);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (bus.off_req && (state_q != ST_OFF)) begin
      state_d = dly_zero_c ? ST_OFF : ST_ARM_OFF;
      cnt_d   = dly_load_c;
    end else if (bus.on_req && !bus.off_req && (state_q != ST_ON)) begin
      state_d = dly_zero_c ? ST_ON : ST_ARM_ON;
      cnt_d   = dly_load_c;
    end else if (arming_c) begin
      if (cnt_q == '0) begin
        state_d = (state_q == ST_ARM_ON) ? ST_ON : ST_OFF;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
    chk_en_d = (state_d == ST_ON);
    busy_d   = (state_d == ST_ARM_ON) || (state_d == ST_ARM_OFF);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_OFF;
      cnt_q      <= '0;
      chk_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      fail_irq_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      chk_en_q   <= chk_en_d;
      busy_q     <= busy_d;
      fail_irq_q <= cnt_fail_c;
    end
  end

  // Results only count while the registered window is open in the same cycle.
  assign cnt_pass_c = chk_en_q && bus.chk_valid && bus.chk_pass;
  assign cnt_fail_c = chk_en_q && bus.chk_valid && !bus.chk_pass;

  sat_counter #(.W(ERR_W)) u_pass_cnt (
    .clk (clk),
    .rst (rst),
    .clr (bus.clr_cnt),
    .inc (cnt_pass_c),
    .q   (bus.pass_cnt)
  );

  sat_counter #(.W(ERR_W)) u_fail_cnt (
    .clk (clk),
    .rst (rst),
    .clr (bus.clr_cnt),
    .inc (cnt_fail_c),
    .q   (bus.fail_cnt)
  );

  assign bus.chk_en   = chk_en_q;
  assign bus.state    = state_q;
  assign bus.busy     = busy_q;
  assign bus.fail_irq = fail_irq_q;

endmodule

// File: tb/tb_assert_window_ctrl.sv
// Scoreboard bench for assert_window_ctrl: directed scenarios plus random traffic
// checked against a time-based behavioural model.
module tb_assert_window_ctrl;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned ERR_W = 4;
  localparam int          MAXC  = (1 << ERR_W) - 1;

  typedef struct {
    bit en;
    int st;
    bit busy;
    int pass;
    int fail;
    bit irq;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  assert_window_ctrl_if #(.CNT_W(CNT_W), .ERR_W(ERR_W)) bus ();

  assert_window_ctrl #(.CNT_W(CNT_W), .ERR_W(ERR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   irq_seen = 0;
  int   en_seen  = 0;

  // Model: settled mode plus an optional pending transition due at an absolute cycle.
  bit m_mode, m_pend, m_tgt, m_irq;
  int m_fire, m_cyc, m_pass, m_fail;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_pend = 0; m_tgt = 0; m_irq = 0;
    m_fire = 0; m_cyc = 0; m_pass = 0; m_fail = 0;
  endtask

  task automatic model_arm(input bit tgt, input int d);
    if (d == 0) begin
      m_mode = tgt;
      m_pend = 0;
    end else begin
      m_pend = 1;
      m_tgt  = tgt;
      m_fire = m_cyc + 1 + d;
    end
  endtask

  task automatic model_step(input bit on, input bit off, input int d,
                            input bit v, input bit p, input bit clr);
    bit en_now;
    en_now = !m_pend && m_mode;
    m_irq  = en_now && v && !p;
    if (clr) begin
      m_pass = 0;
      m_fail = 0;
    end else if (en_now && v) begin
      if (p && m_pass < MAXC) m_pass++;
      if (!p && m_fail < MAXC) m_fail++;
    end
    if (off && (m_pend || m_mode)) model_arm(1'b0, d);
    else if (on && !off && (m_pend || !m_mode)) model_arm(1'b1, d);
    m_cyc++;
    if (m_pend && m_cyc == m_fire) begin
      m_mode = m_tgt;
      m_pend = 0;
    end
  endtask

  task automatic drive(input bit on, input bit off, input int d,
                       input bit v, input bit p, input bit clr);
    exp_t e;
    @(negedge clk);
    bus.on_req    = on;
    bus.off_req   = off;
    bus.delay     = CNT_W'(d);
    bus.chk_valid = v;
    bus.chk_pass  = p;
    bus.clr_cnt   = clr;
    model_step(on, off, d, v, p, clr);
    e.en   = !m_pend && m_mode;
    e.st   = m_pend ? (m_tgt ? 1 : 3) : (m_mode ? 2 : 0);
    e.busy = m_pend;
    e.pass = m_pass;
    e.fail = m_fail;
    e.irq  = m_irq;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Asynchronous reset applied away from the clock edge; outputs must clear at once.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.on_req = 0; bus.off_req = 0; bus.delay = '0;
    bus.chk_valid = 0; bus.chk_pass = 0; bus.clr_cnt = 0;
    #1;
    check("rst_chk_en", int'(bus.chk_en), 0);
    check("rst_state", int'(bus.state), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_pass_cnt", int'(bus.pass_cnt), 0);
    check("rst_fail_cnt", int'(bus.fail_cnt), 0);
    check("rst_fail_irq", int'(bus.fail_irq), 0);
    exp_q.delete();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      check("chk_en", int'(bus.chk_en), int'(mon_e.en));
      check("state", int'(bus.state), mon_e.st);
      check("busy", int'(bus.busy), int'(mon_e.busy));
      check("pass_cnt", int'(bus.pass_cnt), mon_e.pass);
      check("fail_cnt", int'(bus.fail_cnt), mon_e.fail);
      check("fail_irq", int'(bus.fail_irq), int'(mon_e.irq));
    end
    if (bus.fail_irq) irq_seen++;
    if (bus.chk_en) en_seen++;
  end

  initial begin
    int i0, e0;
    bus.on_req = 0; bus.off_req = 0; bus.delay = '0;
    bus.chk_valid = 0; bus.chk_pass = 0; bus.clr_cnt = 0;
    model_reset();
    do_reset();

    // Fails with the window closed are discarded.
    i0 = irq_seen;
    repeat (10) drive(0, 0, 0, 1, 0, 0);
    settle();
    check("closed_fail_cnt", int'(bus.fail_cnt), 0);
    check("closed_irq_pulses", irq_seen - i0, 0);
    check("closed_chk_en", int'(bus.chk_en), 0);

    // Open immediately, count 4 passes and 2 fails, then clear with a colliding fail.
    drive(1, 0, 0, 0, 0, 0);
    i0 = irq_seen;
    drive(0, 0, 0, 1, 1, 0);
    drive(0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 1, 1, 0);
    drive(0, 0, 0, 1, 1, 0);
    drive(0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 1, 1, 0);
    idle(1);
    settle();
    check("win_pass_cnt", int'(bus.pass_cnt), 4);
    check("win_fail_cnt", int'(bus.fail_cnt), 2);
    check("win_irq_pulses", irq_seen - i0, 2);
    drive(0, 0, 0, 1, 0, 1);
    settle();
    check("clr_fail_cnt", int'(bus.fail_cnt), 0);
    check("clr_pass_cnt", int'(bus.pass_cnt), 0);
    drive(0, 1, 3, 0, 0, 0);
    idle(5);
    settle();
    check("delayed_off_state", int'(bus.state), 0);

    // Pending enable cancelled by an immediate disable: window never opens.
    e0 = en_seen;
    drive(1, 0, 5, 0, 0, 0);
    idle(1);
    drive(0, 1, 0, 0, 0, 0);
    idle(7);
    settle();
    check("cancel_en_cycles", en_seen - e0, 0);
    check("cancel_state", int'(bus.state), 0);
    drive(1, 1, 0, 0, 0, 0);
    idle(1);
    settle();
    check("both_req_state", int'(bus.state), 0);

    // Fail counter saturates while every counted fail still pulses the irq.
    drive(1, 0, 0, 0, 0, 0);
    i0 = irq_seen;
    repeat (20) drive(0, 0, 0, 1, 0, 0);
    idle(1);
    settle();
    check("sat_fail_cnt", int'(bus.fail_cnt), MAXC);
    check("sat_irq_pulses", irq_seen - i0, 20);
    drive(0, 1, 0, 0, 0, 0);
    drive(1, 0, 200, 0, 0, 0);
    idle(10);
    settle();
    check("long_arm_state", int'(bus.state), 1);
    do_reset();

    // Random traffic against the model, with occasional clears and resets.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        drive(($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0),
              ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 255))
                                           : int'($urandom_range(0, 4)),
              bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
              ($urandom_range(0, 39) == 0));
      end
    end
    idle(2);
    settle();
    settle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/assert_window_ctrl.md
# assert_window_ctrl

Synthesizable controller that gates when an attached checker's results count. It is the hardware equivalent of delayed `$assertoff`/`$asserton` windows. Off/on requests carry a cycle delay; a four-state sequencer applies them and drives `chk_en`. While checking is enabled, the block counts checker pass and fail outcomes. It sits between a stimulus/config master and the checker of a small combinational datapath, for example an `y = a|b` check.

## Interface
Parameters:
- `CNT_W`, 8: width of the delay field and the delay counter.
- `ERR_W`, 16: width of the pass and fail counters.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `on_req`  in  1  request to enable checking, sampled every cycle.
- `off_req`  in  1  request to disable checking, sampled every cycle.
- `delay`  in  CNT_W  delay in cycles, captured with whichever request is accepted.
- `chk_valid`  in  1  checker produced a result this cycle.
- `chk_pass`  in  1  result polarity, valid with `chk_valid`: 1 = pass, 0 = fail.
- `clr_cnt`  in  1  synchronous clear of both counters.
- `chk_en`  out  1  checking window active.
- `state`  out  2  current sequencer state, encoded per the package.
- `busy`  out  1  a delayed transition is pending (ARM_ON or ARM_OFF).
- `pass_cnt`  out  ERR_W  saturating pass count.
- `fail_cnt`  out  ERR_W  saturating fail count.
- `fail_irq`  out  1  one-cycle pulse for each counted fail.

## Operation
- States: OFF=0, ARM_ON=1, ON=2, ARM_OFF=3. `chk_en`=1 only in ON. `busy`=1 in ARM_ON and ARM_OFF.
- Reset values: state OFF, `chk_en`=0, `busy`=0, counters 0, delay counter 0, `fail_irq`=0. Checking is off until explicitly requested.
- Accepting a request with delay D:
  - D=0: go straight to the target state (ON or OFF).
  - D>0: go to the matching ARM state and load the counter with D-1.
- ARM states: when the counter is 0, enter the target state; otherwise decrement.
- Request priority:
  - `off_req` and `on_req` in the same cycle: `off_req` wins and `on_req` is dropped.
  - `on_req` in ON, or `off_req` in OFF: ignored.
  - Same-direction request while arming: the counter restarts with the new delay.
  - Opposite request while arming: cancels the pending transition and arms the other direction with its own delay. D=0 goes directly to the target state.
- Counting happens only when `chk_en` && `chk_valid`:
  - `chk_pass`=1 increments `pass_cnt`; `chk_pass`=0 increments `fail_cnt`.
  - Both counters saturate at all-ones and never wrap.
  - `chk_valid` outside ON is discarded.
- `clr_cnt` takes priority over an increment in the same cycle: the result is 0.
- `fail_irq` pulses for a counted fail even when `fail_cnt` is already saturated.
- Counters retain their values across OFF/ON transitions; only `rst` and `clr_cnt` clear them.

## Timing
- Request sampled in cycle k with delay D: the state change is visible from cycle k+1+D. D=0 means the new state holds from cycle k+1.
- `chk_en` is registered and changes only on state transitions.
- A `chk_valid` in cycle k is counted only if `chk_en`=1 in that same cycle k.
- `pass_cnt`/`fail_cnt` update at the end of cycle k and are visible in cycle k+1. `fail_irq` is high in cycle k+1.
- `rst` asserted mid-arm or mid-window: immediate asynchronous return to the reset values. A pending delay is lost.
- Maximum delay is 2^CNT_W − 1. The counter never underflows.

## Structure
- Package `assert_ctrl_pkg` holds:
  - the `state_t` enum (2-bit encoding above);
  - a localparam for the default widths.
- Sub-module `sat_counter`, parameter W, with ports `clk`, `rst`, `clr`, `inc`, `q`. It is instantiated twice, once for pass and once for fail.
- Top level contains the sequencer, the delay counter and the irq register.

## Test plan
- Reset, then `chk_valid`=1 with `chk_pass`=0 for 10 cycles and no requests -> `chk_en`=0, `fail_cnt`=0, `fail_irq` never pulses.
- `on_req` with D=0 in cycle 5 -> `chk_en`=1 from cycle 6. Then `off_req` with D=3 in cycle 20 -> `busy`=1 in cycles 21–23, `chk_en`=0 from cycle 24.
- In ON, 4 passes and 2 fails -> `pass_cnt`=4, `fail_cnt`=2, two one-cycle `fail_irq` pulses each one cycle after its fail. `clr_cnt` together with a fail in the same cycle -> `fail_cnt`=0.
- `on_req` with D=5 in OFF, then `off_req` with D=0 two cycles later -> OFF on the next cycle and `chk_en` never asserts. Then `on_req` and `off_req` together in OFF -> stays OFF.
- CNT_W=8, ERR_W=4: 20 fails in ON -> `fail_cnt` stays at 15 and `fail_irq` pulses 20 times. Assert `rst` during an ARM_ON with D=200 -> state OFF immediately and all counters 0.
